// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Drives per-digit BCD codes for seven-segment decoders; overflow shows code 12 (dash) on every digit.
module bin2bcd_seq #(
    parameter int unsigned IN_W   = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(IN_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state;
    logic [IN_W-1:0] sh;
    logic [SW-1:0]   scratch;
    logic [CW-1:0]   cnt;
    logic            ovf_acc;

    logic [SW-1:0]   adj;
    logic [SW-1:0]   nxt_scratch;
    logic [IN_W-1:0] nxt_sh;
    logic            carry_out;
    logic            last;

    // Add-3 correction on every digit >= 5, then one left shift of {scratch, sh}.
    always_comb begin
        adj = scratch;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        carry_out   = adj[SW-1];
        nxt_scratch = {adj[SW-2:0], sh[IN_W-1]};
        nxt_sh      = {sh[IN_W-2:0], 1'b0};
        last        = (cnt == CW'(IN_W - 1));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            sh      <= '0;
            scratch <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sh      <= bin;
                        scratch <= '0;
                        cnt     <= '0;
                        ovf_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    sh      <= nxt_sh;
                    scratch <= nxt_scratch;
                    cnt     <= cnt + CW'(1);
                    ovf_acc <= ovf_acc | carry_out;
                    // Final iteration publishes the result; intermediate scratch never reaches bcd.
                    if (last) begin
                        if (ovf_acc | carry_out) begin
                            bcd <= {DIGITS{4'd12}};
                            ovf <= 1'b1;
                        end else begin
                            bcd <= nxt_scratch;
                            ovf <= 1'b0;
                        end
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: 5-digit and 4-digit instances against a decimal model.
`timescale 1ns/1ps
module tb_bin2bcd_seq;

    logic        clk;
    logic        rstn;
    logic        start5, start4;
    logic [15:0] bin5, bin4;
    logic        busy5, done5, ovf5;
    logic        busy4, done4, ovf4;
    logic [19:0] bcd5;
    logic [15:0] bcd4;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.IN_W(16), .DIGITS(5)) dut5 (
        .clk(clk), .rstn(rstn), .start(start5), .bin(bin5),
        .busy(busy5), .done(done5), .bcd(bcd5), .ovf(ovf5)
    );

    bin2bcd_seq #(.IN_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .bin(bin4),
        .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: digits of v as BCD nibbles, or all 12s if v needs more than n digits.
    function automatic logic [19:0] ref_bcd(input int unsigned v, input int unsigned n);
        logic [19:0] r;
        int unsigned lim;
        int unsigned x;
        r   = '0;
        lim = 1;
        for (int i = 0; i < int'(n); i++) lim = lim * 10;
        if (v >= lim) begin
            for (int i = 0; i < int'(n); i++) r[4*i +: 4] = 4'd12;
        end else begin
            x = v;
            for (int i = 0; i < int'(n); i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    function automatic bit ref_ovf(input int unsigned v, input int unsigned n);
        int unsigned lim;
        lim = 1;
        for (int i = 0; i < int'(n); i++) lim = lim * 10;
        return v >= lim;
    endfunction

    function automatic bit digits_ok(input logic [19:0] b, input int unsigned n);
        for (int i = 0; i < int'(n); i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    // Called at #1 after an edge; issues start and waits (bounded) for done. lat=-1 on timeout.
    task automatic run5(input logic [15:0] v, output logic [19:0] b, output logic o,
                        output int lat, output int bcyc);
        start5 = 1'b1;
        bin5   = v;
        @(posedge clk); #1;
        start5 = 1'b0;
        bin5   = 16'($urandom);
        lat  = 0;
        bcyc = 0;
        while (done5 !== 1'b1) begin
            if (busy5 === 1'b1) bcyc++;
            if (lat >= 100) begin
                lat = -1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        b = bcd5;
        o = ovf5;
    endtask

    task automatic run4(input logic [15:0] v, output logic [15:0] b, output logic o,
                        output int lat);
        start4 = 1'b1;
        bin4   = v;
        @(posedge clk); #1;
        start4 = 1'b0;
        bin4   = 16'($urandom);
        lat = 0;
        while (done4 !== 1'b1) begin
            if (lat >= 100) begin
                lat = -1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        b = bcd4;
        o = ovf4;
    endtask

    task automatic test_reset();
        rstn   = 1'b0;
        start5 = 1'b0;
        start4 = 1'b0;
        bin5   = '0;
        bin4   = '0;
        #12;
        checks++;
        if ({busy5, done5, ovf5, bcd5} !== 23'h0) begin
            errors++;
            $display("FAIL reset5 busy=%b done=%b ovf=%b bcd=%h want 0", busy5, done5, ovf5, bcd5);
        end
        checks++;
        if ({busy4, done4, ovf4, bcd4} !== 19'h0) begin
            errors++;
            $display("FAIL reset4 busy=%b done=%b ovf=%b bcd=%h want 0", busy4, done4, ovf4, bcd4);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [15:0] vals [3];
        logic [19:0] b;
        logic        o;
        int          lat, bc;
        vals[0] = 16'd0; vals[1] = 16'd65535; vals[2] = 16'd1234;
        foreach (vals[k]) begin
            run5(vals[k], b, o, lat, bc);
            checks++;
            if (lat != 16) begin
                errors++;
                $display("FAIL basic_lat v=%0d got %0d want 16", vals[k], lat);
            end
            checks++;
            if (bc != 16) begin
                errors++;
                $display("FAIL basic_busy v=%0d got %0d want 16", vals[k], bc);
            end
            checks++;
            if (b !== ref_bcd(vals[k], 5) || o !== 1'b0) begin
                errors++;
                $display("FAIL basic_bcd v=%0d got %h/%b want %h/0", vals[k], b, o, ref_bcd(vals[k], 5));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        logic [19:0] b;
        logic        o;
        int          lat, bc, ndone, cyc;
        start5 = 1'b1;
        bin5   = 16'd4321;
        @(posedge clk); #1;
        start5 = 1'b0;
        cyc   = 0;
        ndone = 0;
        while (done5 !== 1'b1 && cyc < 100) begin
            if (cyc == 3 || cyc == 10) begin
                start5 = 1'b1;
                bin5   = 16'(cyc * 1111);
            end else begin
                start5 = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start5 = 1'b0;
        checks++;
        if (cyc != 16) begin
            errors++;
            $display("FAIL ignore_lat got %0d want 16", cyc);
        end
        checks++;
        if (bcd5 !== 20'h04321 || ovf5 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_bcd got %h/%b want 04321/0", bcd5, ovf5);
        end
        // Start during the done cycle is accepted immediately.
        run5(16'd9, b, o, lat, bc);
        checks++;
        if (lat != 16 || b !== 20'h00009 || o !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back got lat=%0d bcd=%h ovf=%b want 16/00009/0", lat, b, o);
        end
        // No stray done after the ignored starts.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done5 === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL ignore_extra_done got %0d want 0", ndone);
        end
    endtask

    task automatic test_overflow4();
        logic [15:0] vals [3];
        logic [15:0] b;
        logic        o;
        int          lat;
        vals[0] = 16'd9999; vals[1] = 16'd10000; vals[2] = 16'd1;
        foreach (vals[k]) begin
            run4(vals[k], b, o, lat);
            checks++;
            if (lat != 16 || b !== ref_bcd(vals[k], 4)[15:0] || o !== ref_ovf(vals[k], 4)) begin
                errors++;
                $display("FAIL ovf4 v=%0d got lat=%0d bcd=%h ovf=%b want 16/%h/%b",
                         vals[k], lat, b, o, ref_bcd(vals[k], 4)[15:0], ref_ovf(vals[k], 4));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort();
        logic [19:0] b;
        logic        o;
        int          lat, bc, ndone;
        run5(16'd777, b, o, lat, bc);
        checks++;
        if (lat != 16 || b !== 20'h00777) begin
            errors++;
            $display("FAIL abort_pre got lat=%0d bcd=%h want 16/00777", lat, b);
        end
        @(posedge clk); #1;
        start5 = 1'b1;
        bin5   = 16'd500;
        @(posedge clk); #1;
        start5 = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (busy5 !== 1'b0 || bcd5 !== 20'h0 || ovf5 !== 1'b0 || done5 !== 1'b0) begin
            errors++;
            $display("FAIL abort_async busy=%b bcd=%h ovf=%b done=%b want 0", busy5, bcd5, ovf5, done5);
        end
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done5 === 1'b1 || busy5 === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d active cycles want 0", ndone);
        end
        run5(16'd500, b, o, lat, bc);
        checks++;
        if (lat != 16 || b !== 20'h00500 || o !== 1'b0) begin
            errors++;
            $display("FAIL abort_post got lat=%0d bcd=%h ovf=%b want 16/00500/0", lat, b, o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_sweep();
        logic [19:0] b;
        logic [15:0] b4;
        logic        o;
        logic [15:0] v;
        int          lat, bc;
        for (int n = 0; n < 1000; n++) begin
            v = 16'($urandom);
            run5(v, b, o, lat, bc);
            checks++;
            if (lat != 16 || b !== ref_bcd(v, 5) || o !== 1'b0 || !digits_ok(b, 5)) begin
                errors++;
                $display("FAIL sweep5 v=%0d got lat=%0d bcd=%h ovf=%b want 16/%h/0", v, lat, b, o, ref_bcd(v, 5));
            end
        end
        @(posedge clk); #1;
        for (int n = 0; n < 200; n++) begin
            v = (n % 2 == 0) ? 16'($urandom_range(0, 9999)) : 16'($urandom);
            run4(v, b4, o, lat);
            checks++;
            if (lat != 16 || b4 !== ref_bcd(v, 4)[15:0] || o !== ref_ovf(v, 4)
                || (o === 1'b0 && !digits_ok({4'd0, b4}, 4))) begin
                errors++;
                $display("FAIL sweep4 v=%0d got lat=%0d bcd=%h ovf=%b want 16/%h/%b",
                         v, lat, b4, o, ref_bcd(v, 4)[15:0], ref_ovf(v, 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore_start();
        test_overflow4();
        test_reset_abort();
        test_random_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
